// File: rtl/t05_cb_pkg.sv
// t05_cb_pkg
// Shared definitions for the depth-first codebook synthesis stage.
//   cb_dfs_state_t : traversal FSM states
//   null_child()   : encoding of an absent child for a given character width
//   child_is_leaf(), child_is_sum(), child_low() : child-field decode helpers
// The helpers take the child field zero-extended to 32 bits so they work for
// any CHAR_W/IDX_W the instantiating module is built with.
package t05_cb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DESCEND,
    ST_EMIT,
    ST_POP,
    ST_DONE,
    ST_ERROR
  } cb_dfs_state_t;

  // Absent child: MSB and bit CHAR_W-1 set, everything else clear.
  function automatic logic [31:0] null_child(input int char_w);
    return (32'd1 << char_w) | (32'd1 << (char_w - 1));
  endfunction

  // A clear MSB marks a leaf carrying a character.
  function automatic logic child_is_leaf(input logic [31:0] child, input int char_w);
    return ((child >> char_w) & 32'd1) == 32'd0;
  endfunction

  // MSB set with bit CHAR_W-1 clear marks a pointer to another tree node.
  function automatic logic child_is_sum(input logic [31:0] child, input int char_w);
    return (((child >> char_w) & 32'd1) != 32'd0) &&
           (((child >> (char_w - 1)) & 32'd1) == 32'd0);
  endfunction

  // Low w bits of a child field (character or node index).
  function automatic logic [31:0] child_low(input logic [31:0] child, input int w);
    return child & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/t05_cb_stack.sv
// t05_cb_stack
// Synchronous LIFO holding pending right children during the tree walk.
//   clk, rst   : clock, synchronous active-high reset (clears sp only)
//   clear      : empty the stack (new traversal)
//   push       : write wr_data at sp, sp+1
//   replace    : overwrite the top entry with wr_data, sp unchanged
//   pop        : discard the top entry, sp-1
//   top        : current top entry (valid when !empty)
//   sp, empty  : occupancy
module t05_cb_stack #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 9,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] top,
  output logic [SP_W-1:0]  sp,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    push_addr;

  always_comb begin
    top_addr  = (sp_q == '0) ? '0 : AW'(sp_q - SP_W'(1));
    push_addr = AW'(sp_q);
    sp_d      = sp_q;
    if (clear) begin
      sp_d = '0;
    end else if (push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop && (sp_q != '0)) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  // Storage needs no reset: entries are only read below sp.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push) begin
        mem_q[push_addr] <= wr_data;
      end else if (replace) begin
        mem_q[top_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign top   = mem_q[top_addr];
  assign sp    = sp_q;
  assign empty = (sp_q == '0);

endmodule

// File: rtl/t05_cb_synth_dfs.sv
// t05_cb_synth_dfs
// Depth-first walk of the Huffman tree in HTREE SRAM; emits one
// (character, code bits, code length) record per leaf.
//   clk, rst           : clock, synchronous active-high reset
//   start, root_idx    : begin a traversal from root_idx (ignored while busy)
//   node_req/node_idx  : SRAM read request, held until node_valid
//   node_valid/node_data : SRAM response {left child, right child}
//   code_valid/code_ready : record handshake towards header synthesis
//   code_char/bits/len : record payload, stable while code_valid
//   busy, done, err_depth : status levels for the controller
module t05_cb_synth_dfs
  import t05_cb_pkg::*;
#(
  parameter int CHAR_W    = 8,
  parameter int IDX_W     = 7,
  parameter int MAX_DEPTH = 128,
  parameter int LEN_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IDX_W-1:0]        root_idx,
  output logic                    node_req,
  output logic [IDX_W-1:0]        node_idx,
  input  logic                    node_valid,
  input  logic [2*CHAR_W+1:0]     node_data,
  output logic                    code_valid,
  input  logic                    code_ready,
  output logic [CHAR_W-1:0]       code_char,
  output logic [MAX_DEPTH-1:0]    code_bits,
  output logic [LEN_W-1:0]        code_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err_depth
);

  localparam int CHILD_W = CHAR_W + 1;
  localparam int SP_W    = $clog2(MAX_DEPTH + 1);
  localparam logic [CHILD_W-1:0]   NULL_C   = CHILD_W'(null_child(CHAR_W));
  localparam logic [MAX_DEPTH-1:0] CODE_ONE = MAX_DEPTH'(1);

  cb_dfs_state_t        state_q, state_d;
  logic [IDX_W-1:0]     node_idx_q, node_idx_d;
  logic [SP_W-1:0]      depth_q, depth_d;
  logic [MAX_DEPTH-1:0] code_q, code_d;
  logic [CHILD_W-1:0]   left_q, left_d;
  logic [CHILD_W-1:0]   right_q, right_d;
  logic                 code_valid_q, code_valid_d;
  logic [CHAR_W-1:0]    code_char_q, code_char_d;
  logic [MAX_DEPTH-1:0] code_bits_q, code_bits_d;
  logic [LEN_W-1:0]     code_len_q, code_len_d;
  logic                 node_req_q, node_req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 stk_clear, stk_push, stk_pop, stk_replace;
  logic [CHILD_W-1:0]   stk_wr_data, stk_top;
  logic [SP_W-1:0]      stk_sp, pop_pos;
  logic                 stk_empty;

  logic                 l_leaf, l_sum, t_leaf, t_sum;
  logic [CHAR_W-1:0]    l_char, t_char;
  logic [IDX_W-1:0]     l_idx, t_idx;

  t05_cb_stack #(
    .DEPTH (MAX_DEPTH),
    .WIDTH (CHILD_W),
    .SP_W  (SP_W)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clear   (stk_clear),
    .push    (stk_push),
    .pop     (stk_pop),
    .replace (stk_replace),
    .wr_data (stk_wr_data),
    .top     (stk_top),
    .sp      (stk_sp),
    .empty   (stk_empty)
  );

  // Decode of the latched left child and of the stack top. Anything that is
  // neither a leaf nor a sum node is handled as an absent child.
  always_comb begin
    l_leaf  = child_is_leaf(32'(left_q), CHAR_W);
    l_sum   = child_is_sum(32'(left_q), CHAR_W);
    l_char  = CHAR_W'(child_low(32'(left_q), CHAR_W));
    l_idx   = IDX_W'(child_low(32'(left_q), IDX_W));
    t_leaf  = child_is_leaf(32'(stk_top), CHAR_W);
    t_sum   = child_is_sum(32'(stk_top), CHAR_W);
    t_char  = CHAR_W'(child_low(32'(stk_top), CHAR_W));
    t_idx   = IDX_W'(child_low(32'(stk_top), IDX_W));
    pop_pos = stk_sp - SP_W'(1);
  end

  // Traversal control. Stack entry i always holds the pending right child of
  // the branch at depth i, so sp equals depth whenever a node is descended.
  // A right child that has been taken is overwritten with NULL rather than
  // removed, keeping that slot aligned with its depth; such tombstones are
  // discarded one per POP cycle as the walk unwinds.
  always_comb begin
    state_d      = state_q;
    node_idx_d   = node_idx_q;
    depth_d      = depth_q;
    code_d       = code_q;
    left_d       = left_q;
    right_d      = right_q;
    code_valid_d = code_valid_q;
    code_char_d  = code_char_q;
    code_bits_d  = code_bits_q;
    code_len_d   = code_len_q;
    stk_clear    = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_replace  = 1'b0;
    stk_wr_data  = right_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          stk_clear  = 1'b1;
          depth_d    = '0;
          code_d     = '0;
          node_idx_d = root_idx;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (node_valid) begin
          left_d  = node_data[2*CHILD_W-1:CHILD_W];
          right_d = node_data[CHILD_W-1:0];
          state_d = ST_DESCEND;
        end
      end

      ST_DESCEND: begin
        if ((depth_q == '0) && !l_leaf && !l_sum) begin
          state_d = ST_DONE;
        end else if (depth_q == SP_W'(MAX_DEPTH)) begin
          state_d = ST_ERROR;
        end else begin
          stk_push    = 1'b1;
          stk_wr_data = right_q;
          code_d      = code_q & ~(CODE_ONE << depth_q);
          depth_d     = depth_q + SP_W'(1);
          if (l_leaf) begin
            code_valid_d = 1'b1;
            code_char_d  = l_char;
            code_bits_d  = code_d;
            code_len_d   = LEN_W'(depth_q + SP_W'(1));
            state_d      = ST_EMIT;
          end else if (l_sum) begin
            node_idx_d = l_idx;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_POP;
          end
        end
      end

      ST_EMIT: begin
        if (code_ready) begin
          code_valid_d = 1'b0;
          state_d      = ST_POP;
        end
      end

      ST_POP: begin
        if (stk_empty) begin
          state_d = ST_DONE;
        end else if (!t_leaf && !t_sum) begin
          stk_pop = 1'b1;
        end else begin
          stk_replace = 1'b1;
          stk_wr_data = NULL_C;
          code_d      = (code_q & ((CODE_ONE << pop_pos) - CODE_ONE)) |
                        (CODE_ONE << pop_pos);
          depth_d     = stk_sp;
          if (t_leaf) begin
            code_valid_d = 1'b1;
            code_char_d  = t_char;
            code_bits_d  = code_d;
            code_len_d   = LEN_W'(stk_sp);
            state_d      = ST_EMIT;
          end else begin
            node_idx_d = t_idx;
            state_d    = ST_FETCH;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    node_req_d = (state_d == ST_FETCH);
    busy_d     = (state_d == ST_FETCH) || (state_d == ST_DESCEND) ||
                 (state_d == ST_EMIT)  || (state_d == ST_POP);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      node_idx_q   <= '0;
      depth_q      <= '0;
      code_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      code_valid_q <= 1'b0;
      code_char_q  <= '0;
      code_bits_q  <= '0;
      code_len_q   <= '0;
      node_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      node_idx_q   <= node_idx_d;
      depth_q      <= depth_d;
      code_q       <= code_d;
      left_q       <= left_d;
      right_q      <= right_d;
      code_valid_q <= code_valid_d;
      code_char_q  <= code_char_d;
      code_bits_q  <= code_bits_d;
      code_len_q   <= code_len_d;
      node_req_q   <= node_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign node_req   = node_req_q;
  assign node_idx   = node_idx_q;
  assign code_valid = code_valid_q;
  assign code_char  = code_char_q;
  assign code_bits  = code_bits_q;
  assign code_len   = code_len_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_depth  = err_q;

endmodule
